// File: rtl/decode_stage_hs.sv
// Decode stage between fetch and execute. {ir,pc} pairs wait in a small FIFO; the
// head is decoded into a registered bundle that is held until execute accepts it.
module decode_stage_hs #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ir,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [4:0]               out_alucode,
  output logic                     out_using_r2,
  output logic                     out_using_pc,
  output logic                     out_write_reg,
  output logic [2:0]               out_info_load,
  output logic [1:0]               out_info_store,
  output logic [3:0]               out_info_branch,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;
  localparam logic [4:0] ALU_JAL    = 5'd18;
  localparam logic [4:0] ALU_JALR   = 5'd19;
  localparam logic [4:0] ALU_UNUSED = 5'd31;

  localparam logic [2:0] LD_NOT = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                         LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [1:0] ST_NOT = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
  localparam logic [3:0] BR_NOT = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BLT = 4'd3,
                         BR_BGE = 4'd4, BR_BLTU = 4'd5, BR_BGEU = 4'd6,
                         BR_JAL = 4'd7, BR_JALR = 4'd8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [4:0]      alucode;
    logic            using_r2;
    logic            using_pc;
    logic            write_reg;
    logic [2:0]      info_load;
    logic [1:0]      info_store;
    logic [3:0]      info_branch;
    logic            illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{alucode: ALU_UNUSED, default: '0};

  // ---------------- input FIFO ----------------
  logic [31:0]     ir_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, load;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = ~full & ~flush;
  assign push       = in_valid & in_ready;
  assign load       = ~empty & (~out_valid | out_ready) & ~flush;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr] <= in_ir;
      pc_mem[wr_ptr] <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- head decode ----------------
  logic [31:0]     hir;
  logic [XLEN-1:0] hpc;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  bundle_t         dec;
  logic            bad;

  assign hir   = ir_mem[rd_ptr];
  assign hpc   = pc_mem[rd_ptr];
  assign opc   = hir[6:0];
  assign f3    = hir[14:12];
  assign imm_i = XLEN'($signed(hir[31:20]));
  assign imm_s = XLEN'($signed({hir[31:25], hir[11:7]}));
  assign imm_b = XLEN'($signed({hir[31], hir[7], hir[30:25], hir[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({hir[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({hir[31], hir[19:12], hir[20], hir[30:21], 1'b0}));
  assign shamt = XLEN'(hir[20 +: SHW]);

  always_comb begin
    dec = BUNDLE_RST;
    bad = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec.rd        = hir[11:7];
        dec.imm       = imm_u;
        dec.alucode   = ALU_ADD;
        dec.using_pc  = (opc == OPC_AUIPC);
        dec.write_reg = 1'b1;
      end
      OPC_JAL: begin
        dec.rd          = hir[11:7];
        dec.imm         = imm_j;
        dec.alucode     = ALU_JAL;
        dec.using_pc    = 1'b1;
        dec.write_reg   = 1'b1;
        dec.info_branch = BR_JAL;
      end
      OPC_JALR: begin
        dec.rs1         = hir[19:15];
        dec.rd          = hir[11:7];
        dec.imm         = imm_i;
        dec.alucode     = ALU_JALR;
        dec.write_reg   = 1'b1;
        dec.info_branch = BR_JALR;
      end
      OPC_BRANCH: begin
        // ALU forms the target (pc+imm); the comparison kind travels in info_branch
        dec.rs1      = hir[19:15];
        dec.rs2      = hir[24:20];
        dec.imm      = imm_b;
        dec.alucode  = ALU_ADD;
        dec.using_pc = 1'b1;
        case (f3)
          3'b000:  dec.info_branch = BR_BEQ;
          3'b001:  dec.info_branch = BR_BNE;
          3'b100:  dec.info_branch = BR_BLT;
          3'b101:  dec.info_branch = BR_BGE;
          3'b110:  dec.info_branch = BR_BLTU;
          3'b111:  dec.info_branch = BR_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1       = hir[19:15];
        dec.rd        = hir[11:7];
        dec.imm       = imm_i;
        dec.alucode   = ALU_ADD;
        dec.write_reg = 1'b1;
        case (f3)
          3'b000:  dec.info_load = LD_LB;
          3'b001:  dec.info_load = LD_LH;
          3'b010:  dec.info_load = LD_LW;
          3'b100:  dec.info_load = LD_LBU;
          3'b101:  dec.info_load = LD_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1     = hir[19:15];
        dec.rs2     = hir[24:20];
        dec.imm     = imm_s;
        dec.alucode = ALU_ADD;
        case (f3)
          3'b000:  dec.info_store = ST_SB;
          3'b001:  dec.info_store = ST_SH;
          3'b010:  dec.info_store = ST_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.rs1       = hir[19:15];
        dec.rd        = hir[11:7];
        dec.imm       = imm_i;
        dec.write_reg = 1'b1;
        case (f3)
          3'b000: dec.alucode = ALU_ADD;
          3'b001: begin dec.alucode = ALU_SLL; dec.imm = shamt; end
          3'b010: dec.alucode = ALU_SLT;
          3'b011: dec.alucode = ALU_SLTU;
          3'b100: dec.alucode = ALU_XOR;
          3'b101: begin dec.alucode = hir[30] ? ALU_SRA : ALU_SRL; dec.imm = shamt; end
          3'b110: dec.alucode = ALU_OR;
          default: dec.alucode = ALU_AND;
        endcase
      end
      OPC_OP: begin
        dec.rs1       = hir[19:15];
        dec.rs2       = hir[24:20];
        dec.rd        = hir[11:7];
        dec.using_r2  = 1'b1;
        dec.write_reg = 1'b1;
        if (hir[25]) begin
          if (ENABLE_M != 0) begin
            case (f3)
              3'b000: dec.alucode = ALU_MUL;
              3'b001: dec.alucode = ALU_MULH;
              3'b010: dec.alucode = ALU_MULHSU;
              3'b011: dec.alucode = ALU_MULHU;
              3'b100: dec.alucode = ALU_DIV;
              3'b101: dec.alucode = ALU_DIVU;
              3'b110: dec.alucode = ALU_REM;
              default: dec.alucode = ALU_REMU;
            endcase
          end else begin
            bad = 1'b1;
          end
        end else begin
          case (f3)
            3'b000: dec.alucode = hir[30] ? ALU_SUB : ALU_ADD;
            3'b001: dec.alucode = ALU_SLL;
            3'b010: dec.alucode = ALU_SLT;
            3'b011: dec.alucode = ALU_SLTU;
            3'b100: dec.alucode = ALU_XOR;
            3'b101: dec.alucode = hir[30] ? ALU_SRA : ALU_SRL;
            3'b110: dec.alucode = ALU_OR;
            default: dec.alucode = ALU_AND;
          endcase
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = BUNDLE_RST;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.write_reg = 1'b0;
  end

  // ---------------- output register ----------------
  bundle_t         q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= BUNDLE_RST;
      pc_q      <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      // pc is deliberately kept so a trap handler can still see it
      q         <= BUNDLE_RST;
      out_valid <= 1'b0;
    end else if (load) begin
      q         <= dec;
      pc_q      <= hpc;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1         = q.rs1;
  assign out_rs2         = q.rs2;
  assign out_rd          = q.rd;
  assign out_imm         = q.imm;
  assign out_alucode     = q.alucode;
  assign out_using_r2    = q.using_r2;
  assign out_using_pc    = q.using_pc;
  assign out_write_reg   = q.write_reg;
  assign out_info_load   = q.info_load;
  assign out_info_store  = q.info_store;
  assign out_info_branch = q.info_branch;
  assign out_illegal     = q.illegal;
  assign out_pc          = pc_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs: two instances (M enabled / disabled) share
// stimulus; a transaction-level model predicts bundles, occupancy and handshakes.
module tb_decode_stage_hs;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        r2;
    logic        upc;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [3:0]  br;
    logic [31:0] pc;
    logic        ill;
  } bundle_t;

  localparam int BRTAB [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
  localparam int LDTAB [8] = '{1, 2, 3, 0, 4, 5, 0, 0};
  localparam int OPALU [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam int MALU  [8] = '{10, 11, 12, 13, 14, 15, 16, 17};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;

  logic m_in_ready, m_out_valid, m_r2, m_upc, m_wr, m_ill;
  logic [4:0] m_rs1, m_rs2, m_rd, m_alu;
  logic [31:0] m_imm, m_pc;
  logic [2:0] m_ld, m_cnt;
  logic [1:0] m_st;
  logic [3:0] m_br;
  logic n_in_ready, n_out_valid, n_r2, n_upc, n_wr, n_ill;
  logic [4:0] n_rs1, n_rs2, n_rd, n_alu;
  logic [31:0] n_imm, n_pc;
  logic [2:0] n_ld, n_cnt;
  logic [1:0] n_st;
  logic [3:0] n_br;

  decode_stage_hs #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd), .out_imm(m_imm), .out_alucode(m_alu),
    .out_using_r2(m_r2), .out_using_pc(m_upc), .out_write_reg(m_wr), .out_info_load(m_ld),
    .out_info_store(m_st), .out_info_branch(m_br), .out_pc(m_pc), .out_illegal(m_ill),
    .fifo_count(m_cnt));

  decode_stage_hs #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_rs1(n_rs1), .out_rs2(n_rs2), .out_rd(n_rd), .out_imm(n_imm), .out_alucode(n_alu),
    .out_using_r2(n_r2), .out_using_pc(n_upc), .out_write_reg(n_wr), .out_info_load(n_ld),
    .out_info_store(n_st), .out_info_branch(n_br), .out_pc(n_pc), .out_illegal(n_ill),
    .fifo_count(n_cnt));

  bundle_t got_m, got_n;
  assign got_m = {m_rs1, m_rs2, m_rd, m_imm, m_alu, m_r2, m_upc, m_wr, m_ld, m_st, m_br, m_pc, m_ill};
  assign got_n = {n_rs1, n_rs2, n_rd, n_imm, n_alu, n_r2, n_upc, n_wr, n_ld, n_st, n_br, n_pc, n_ill};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bundle_t rst_bundle(input logic [31:0] pc);
    bundle_t b;
    b = '0;
    b.alu = 5'd31;
    b.pc = pc;
    return b;
  endfunction

  // Reference decode straight from the ISA field definitions.
  function automatic bundle_t ref_decode(input logic [31:0] ir, input logic [31:0] pc, input bit em);
    bundle_t b;
    int signed si;
    int f3;
    bit bad;
    si = $signed(ir);
    f3 = int'(ir[14:12]);
    b = rst_bundle(pc);
    bad = 1'b0;
    case (ir[6:0])
      7'h37, 7'h17: begin
        b.rd = ir[11:7]; b.imm = ir & 32'hFFFFF000; b.alu = 5'd0; b.wr = 1'b1;
        b.upc = (ir[6:0] == 7'h17);
      end
      7'h6F: begin
        b.rd = ir[11:7];
        b.imm = ((si >>> 31) << 20) | (int'(ir[19:12]) << 12) | (int'(ir[20]) << 11)
                | (int'(ir[30:21]) << 1);
        b.alu = 5'd18; b.upc = 1'b1; b.wr = 1'b1; b.br = 4'd7;
      end
      7'h67: begin
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.imm = si >>> 20;
        b.alu = 5'd19; b.wr = 1'b1; b.br = 4'd8;
      end
      7'h63: begin
        bad = (f3 == 2 || f3 == 3);
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20];
        b.imm = ((si >>> 31) << 12) | (int'(ir[7]) << 11) | (int'(ir[30:25]) << 5)
                | (int'(ir[11:8]) << 1);
        b.alu = 5'd0; b.upc = 1'b1; b.br = 4'(BRTAB[f3]);
      end
      7'h03: begin
        bad = (f3 == 3 || f3 >= 6);
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.imm = si >>> 20;
        b.alu = 5'd0; b.wr = 1'b1; b.ld = 3'(LDTAB[f3]);
      end
      7'h23: begin
        bad = (f3 >= 3);
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20];
        b.imm = ((si >>> 25) << 5) | int'(ir[11:7]);
        b.alu = 5'd0; b.st = 2'(f3 + 1);
      end
      7'h13: begin
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.wr = 1'b1;
        if (f3 == 1 || f3 == 5) b.imm = int'(ir[24:20]);
        else b.imm = si >>> 20;
        b.alu = (f3 == 5 && ir[30]) ? 5'd7 : 5'(OPALU[f3]);
      end
      7'h33: begin
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20]; b.rd = ir[11:7]; b.wr = 1'b1; b.r2 = 1'b1;
        if (ir[25]) begin
          if (em) b.alu = 5'(MALU[f3]);
          else bad = 1'b1;
        end else if (f3 == 0 && ir[30]) b.alu = 5'd1;
        else if (f3 == 5 && ir[30]) b.alu = 5'd7;
        else b.alu = 5'(OPALU[f3]);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      b = rst_bundle(pc);
      b.ill = 1'b1;
    end
    if (b.rd == 5'd0) b.wr = 1'b0;
    return b;
  endfunction

  // ---------------- transaction model + scoreboard queues ----------------
  bundle_t exp_m[$], exp_n[$];
  logic [31:0] pcq[$];
  int cnt = 0;
  bit ov = 1'b0, flush_chk = 1'b0, pu, po;
  logic [31:0] last_pc = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0; ov = 1'b0; flush_chk = 1'b0; last_pc = '0;
      exp_m.delete(); exp_n.delete(); pcq.delete();
    end else begin
      flush_chk = 1'b0;
      if (flush) begin
        cnt = 0; ov = 1'b0; flush_chk = 1'b1;
        exp_m.delete(); exp_n.delete(); pcq.delete();
      end else begin
        pu = in_valid && (cnt < DEPTH);
        po = (cnt > 0) && (!ov || out_ready);
        if (po) begin
          cnt--; ov = 1'b1; last_pc = pcq.pop_front();
        end else if (ov && out_ready) begin
          ov = 1'b0;
        end
        if (pu) begin
          cnt++;
          pcq.push_back(in_pc);
          exp_m.push_back(ref_decode(in_ir, in_pc, 1'b1));
          exp_n.push_back(ref_decode(in_ir, in_pc, 1'b0));
        end
      end
    end
  end

  // Monitor: compares handshake state every cycle and the bundle while it is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_m", m_in_ready, (cnt < DEPTH) && !flush);
      chk("in_ready_n", n_in_ready, (cnt < DEPTH) && !flush);
      chk("fifo_count", m_cnt, cnt);
      chk("out_valid", m_out_valid, ov);
      chk("out_valid_n", n_out_valid, ov);
      if (flush_chk) begin
        chk("flush_bundle_m", got_m, rst_bundle(last_pc));
        chk("flush_bundle_n", got_n, rst_bundle(last_pc));
      end
      if (ov) begin
        if (exp_m.size() == 0) begin
          chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
          chk("bundle_m", got_m, exp_m[0]);
          chk("bundle_n", got_n, exp_n[0]);
          if (out_ready && !flush) begin
            void'(exp_m.pop_front());
            void'(exp_n.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] ir, input logic [31:0] pc);
    int unsigned n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    forever begin
      @(negedge clk);
      if (m_in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out();
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_out_valid) return;
    end
    chk("out_valid_timeout", 1'b1, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h37;
      1:  r[6:0] = 7'h17;
      2:  r[6:0] = 7'h6F;
      3:  r[6:0] = 7'h67;
      4:  r[6:0] = 7'h63;
      5:  r[6:0] = 7'h03;
      6:  r[6:0] = 7'h23;
      7, 8: r[6:0] = 7'h13;
      9, 10: r[6:0] = 7'h33;
      default: r[6:0] = 7'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_ctr;
    pc_ctr = 32'h1000;

    // Reset state
    idle(3);
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_count", m_cnt, 3'd0);
    chk("rst_bundle", got_m, rst_bundle(32'h0));
    chk("rst_in_ready", m_in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // ADDI x5,x1,-1: one-cycle decode latency, no bypass
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ir = 32'hFFF08293; in_pc = 32'h100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bypass", m_out_valid, 1'b0);
    chk("count_after_push", m_cnt, 3'd1);
    @(negedge clk);
    chk("addi_valid", m_out_valid, 1'b1);
    chk("addi_rd", m_rd, 5'd5);
    chk("addi_rs1", m_rs1, 5'd1);
    chk("addi_imm", m_imm, 32'hFFFFFFFF);
    chk("addi_alu", m_alu, 5'd0);
    chk("addi_wr", m_wr, 1'b1);
    idle(2);

    // Backpressure: one bundle held, FIFO fills
    out_ready = 1'b0;
    send(32'h00208133, 32'h200);
    send(32'h40208133, 32'h204);
    send(32'h0020C133, 32'h208);
    @(negedge clk);
    chk("hold_count", m_cnt, 3'd2);
    chk("hold_in_ready", m_in_ready, 1'b0);
    chk("hold_pc", m_pc, 32'h200);
    idle(2);
    chk("hold_pc_later", m_pc, 32'h200);
    @(posedge clk); #1; out_ready = 1'b1;
    idle(5);

    // Flush with full FIFO and valid output
    out_ready = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200113, 32'h304);
    send(32'h00300193, 32'h308);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'h00400213; in_pc = 32'h30C;
    @(negedge clk);
    chk("flush_in_ready", m_in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", m_cnt, 3'd0);
    chk("flush_valid", m_out_valid, 1'b0);
    chk("flush_pc_kept", m_pc, 32'h300);
    send(32'h00500293, 32'h310);
    expect_out();
    chk("post_flush_rd", m_rd, 5'd5);
    chk("post_flush_pc", m_pc, 32'h310);
    @(posedge clk); #1; out_ready = 1'b1;
    idle(3);

    // MUL with and without the M extension
    out_ready = 1'b0;
    send(32'h022081B3, 32'h400);
    expect_out();
    chk("mul_n_illegal", n_ill, 1'b1);
    chk("mul_n_wr", n_wr, 1'b0);
    chk("mul_n_alu", n_alu, 5'd31);
    chk("mul_n_pc", n_pc, 32'h400);
    chk("mul_m_alu", m_alu, 5'd10);
    chk("mul_m_illegal", m_ill, 1'b0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // x0 write suppression and negative branch offset
    send(32'h00000013, 32'h500);
    expect_out();
    chk("nop_wr", m_wr, 1'b0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    send(32'hFE000EE3, 32'h504);
    expect_out();
    chk("beq_imm", m_imm, 32'hFFFFFFFC);
    chk("beq_br", m_br, 4'd1);
    chk("beq_upc", m_upc, 1'b1);
    @(posedge clk); #1; out_ready = 1'b1;
    idle(2);

    // Randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ir     = rand_instr();
      pc_ctr    = pc_ctr + 32'd4;
      in_pc     = pc_ctr;
      out_ready = (c % 200 < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(8);
    @(negedge clk);
    chk("drain_scoreboard", exp_m.size(), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h00A00513, 32'h600);
    send(32'h00B00593, 32'h604);
    @(negedge clk);
    chk("pre_arst_count", m_cnt, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", m_out_valid, 1'b0);
    chk("arst_count", m_cnt, 3'd0);
    chk("arst_bundle", got_m, rst_bundle(32'h0));
    chk("arst_bundle_n", got_n, rst_bundle(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
